dircc_counter_bank: RTL and testbench

Parametrised multi-channel counter peripheral for the DiRCC processing counter test platform, sitting behind the HPS lightweight bridge as an Avalon-MM slave in the dircc_system fabric. Provides CHANNELS independent WIDTH-bit up/down counters with per-channel compare, auto-reload, external tick gating, sticky match/overflow flags and a combined interrupt to the HPS. It generalises the fixed single-counter test system into a software-configurable counter bank.

---
 rtl/dircc_counter_bank_if.sv | 21 ++
 rtl/dircc_counter_bank.sv | 176 +++++++++++++++++
 tb/tb_dircc_counter_bank.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dircc_counter_bank_if.sv
// Avalon-MM slave bus bundle for dircc_counter_bank (fixed read latency 1, no waitrequest).
interface dircc_counter_bank_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/dircc_counter_bank.sv
// CHANNELS-wide bank of WIDTH-bit up/down counters with compare, reload, sticky flags and irq.
// Optional DIRCC_COUNTER_SNAPSHOT_EN: a channel 0 COUNT read freezes all counts into shadows.
module dircc_counter_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_count,
  input  logic             wr_compare,
  input  logic             wr_status,
  input  logic [31:0]      wdata,
  output logic [4:0]       ctrl_q,
  output logic [WIDTH-1:0] count_q,
  output logic [WIDTH-1:0] compare_q,
  output logic [1:0]       status_q
);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [4:0]       ctrl_d;
  logic [WIDTH-1:0] count_d, compare_d;
  logic [1:0]       status_d, clr;
  logic             step, hit, reload, wrap, match_set, ovf_set;

  always_comb begin
    step      = ctrl_q[0] & (~ctrl_q[1] | tick);
    hit       = (count_q == compare_q);
    reload    = hit & ctrl_q[3];
    wrap      = ctrl_q[2] ? (count_q == '0) : (count_q == ALL_ONES);
    // A COUNT load suppresses the step and its flag evaluation entirely.
    match_set = step & ~wr_count & hit;
    ovf_set   = step & ~wr_count & ~reload & wrap;
    ctrl_d    = wr_ctrl ? wdata[4:0] : ctrl_q;
    compare_d = wr_compare ? wdata[WIDTH-1:0] : compare_q;
    count_d   = count_q;
    if (wr_count) begin
      count_d = wdata[WIDTH-1:0];
    end else if (step) begin
      if (reload) count_d = ctrl_q[2] ? ALL_ONES : '0;
      else        count_d = ctrl_q[2] ? count_q - ONE : count_q + ONE;
    end
    clr      = wr_status ? wdata[1:0] : 2'b00;
    status_d = (status_q & ~clr) | {ovf_set, match_set};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
    end
  end
endmodule

module dircc_counter_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = $clog2(CHANNELS) + 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  dircc_counter_bank_if.slave avs,
  input  logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] match,
  output logic                irq
);
  logic [CHANNELS-1:0][4:0]       ctrl;
  logic [CHANNELS-1:0][WIDTH-1:0] count, compare;
  logic [CHANNELS-1:0][1:0]       status;
  logic [CHANNELS-1:0]            wr_sel;
  logic [31:0]                    chan_sel, rdata;
  logic [1:0]                     reg_sel;
  logic                           chan_ok;
  logic [31:0]                    rdata_q, rdata_d;
  logic                           rvalid_q, rvalid_d, irq_q, irq_d;

  always_comb begin
    chan_sel = 32'(avs.avs_address >> 2);
    reg_sel  = avs.avs_address[1:0];
    chan_ok  = chan_sel < 32'(CHANNELS);
    for (int i = 0; i < CHANNELS; i++)
      wr_sel[i] = avs.avs_write & (chan_sel == 32'(i));
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    dircc_counter_chan #(.WIDTH(WIDTH)) u_chan (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .tick       (tick[g]),
      .wr_ctrl    (wr_sel[g] && reg_sel == 2'd0),
      .wr_count   (wr_sel[g] && reg_sel == 2'd1),
      .wr_compare (wr_sel[g] && reg_sel == 2'd2),
      .wr_status  (wr_sel[g] && reg_sel == 2'd3),
      .wdata      (avs.avs_writedata),
      .ctrl_q     (ctrl[g]),
      .count_q    (count[g]),
      .compare_q  (compare[g]),
      .status_q   (status[g])
    );
  end

`ifdef DIRCC_COUNTER_SNAPSHOT_EN
  localparam int SH_N = (CHANNELS > 1) ? CHANNELS - 1 : 1;
  logic [SH_N-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic                       snap;

  // Shadow slot j holds channel j+1; channel 0 is always read live.
  always_comb begin
    snap     = avs.avs_read & (chan_sel == 32'd0) & (reg_sel == 2'd1);
    shadow_d = shadow_q;
    if (snap)
      for (int j = 0; j < SH_N; j++)
        shadow_d[j] = (j + 1 < CHANNELS) ? count[j+1] : count[0];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) shadow_q <= '0;
    else                shadow_q <= shadow_d;
  end
`endif

  always_comb begin
    rdata = 32'h0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_ok && chan_sel == 32'(i)) begin
        case (reg_sel)
          2'd0: rdata = {27'b0, ctrl[i]};
          2'd1: begin
`ifdef DIRCC_COUNTER_SNAPSHOT_EN
            if (i > 0) rdata = 32'(shadow_q[(i > 0) ? i - 1 : 0]);
            else       rdata = 32'(count[i]);
`else
            rdata = 32'(count[i]);
`endif
          end
          2'd2:    rdata = 32'(compare[i]);
          default: rdata = {30'b0, status[i]};
        endcase
      end
    end
  end

  always_comb begin
    rvalid_d = avs.avs_read;
    rdata_d  = avs.avs_read ? rdata : rdata_q;
    irq_d    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      match[i] = status[i][0];
      irq_d    = irq_d | (status[i][0] & ctrl[i][4]);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;
  assign irq                   = irq_q;
endmodule

// File: tb/tb_dircc_counter_bank.sv
// Directed bench for dircc_counter_bank: 3 channels x 8 bits, so channel 3 addresses are unmapped.
module tb_dircc_counter_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] tick = '0;
  logic [2:0] match;
  logic       irq;
  int         n_vec = 0;
  int         n_err = 0;

  dircc_counter_bank_if #(.ADDR_W(4)) bus();

  dircc_counter_bank #(.CHANNELS(3), .WIDTH(8), .ADDR_W(4)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs           (bus),
    .tick          (tick),
    .match         (match),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    cyc();
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    cyc();
    bus.avs_read    = 1'b0;
    chk({nm, " rdvalid"}, 32'(bus.avs_readdatavalid), 32'd1);
    chk(nm, bus.avs_readdata, exp);
  endtask

  // Channel 0 COUNT read without check; refreshes shadows in the snapshot build.
  task automatic prime();
    bus.avs_address = 4'd1;
    bus.avs_read    = 1'b1;
    cyc();
    bus.avs_read    = 1'b0;
  endtask

  function automatic void add(input bit w, input logic [3:0] a, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] seq [8];
    logic [31:0] snap_exp;
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};

    for (int a = 0; a < 16; a++) add(0, 4'(a), 32'h0, 32'h0);
    add(1, 4'd2,  32'h12,       32'h0);  add(0, 4'd2,  32'h0, 32'h12);
    add(1, 4'd4,  32'hFFFFFFFF, 32'h0);  add(0, 4'd4,  32'h0, 32'h1F);
    add(1, 4'd5,  32'h1234,     32'h0);  add(0, 4'd1,  32'h0, 32'h0);
    add(0, 4'd5,  32'h0,        32'h34);
    add(1, 4'd4,  32'h0,        32'h0);  add(0, 4'd4,  32'h0, 32'h0);
    add(1, 4'd14, 32'hAB,       32'h0);  add(0, 4'd14, 32'h0, 32'h0);
    add(1, 4'd10, 32'h1FF,      32'h0);  add(0, 4'd10, 32'h0, 32'hFF);

    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    cyc(); cyc(); cyc();
    chk("reset rdvalid", 32'(bus.avs_readdatavalid), 32'd0);
    chk("reset rdata", bus.avs_readdata, 32'd0);
    chk("reset match", 32'(match), 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    cyc();

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else           rd(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d a%0d", i, tbl[i].addr));
    end

    // Gated channel 1: three ticks over ten cycles.
    wr(4'd5, 32'h0);
    wr(4'd4, 32'h3);
    for (int c = 0; c < 10; c++) begin
      tick[1] = (c == 2 || c == 5 || c == 8);
      cyc();
    end
    tick = '0;
    prime(); rd(4'd5, 32'd3, "gated count");
    repeat (10) cyc();
    prime(); rd(4'd5, 32'd3, "gated idle");
    chk("gated match1", 32'(match[1]), 32'd1);
    wr(4'd4, 32'h0);
    wr(4'd7, 32'h3);

    // Channel 0 free-run with auto-reload at 5 and irq.
    wr(4'd1, 32'h0);
    wr(4'd2, 32'h5);
    wr(4'd0, 32'h19);
    bus.avs_address = 4'd1;
    bus.avs_read    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("reload count k%0d", k), bus.avs_readdata, seq[k-1]);
      chk($sformatf("reload match k%0d", k), 32'(match[0]), (k >= 6) ? 32'd1 : 32'd0);
      chk($sformatf("reload irq k%0d", k), 32'(irq), (k >= 7) ? 32'd1 : 32'd0);
    end
    bus.avs_read = 1'b0;
    wr(4'd0, 32'h10);
    wr(4'd3, 32'h1);
    chk("clear match", 32'(match[0]), 32'd0);
    chk("clear irq lag", 32'(irq), 32'd1);
    cyc();
    chk("clear irq", 32'(irq), 32'd0);

    // Channel 2 overflow up then down.
    wr(4'd10, 32'h80);
    wr(4'd9, 32'hFF);
    wr(4'd8, 32'h1);
    wr(4'd8, 32'h0);
    prime(); rd(4'd9, 32'h00, "ovf up count");
    rd(4'd11, 32'h2, "ovf up status");
    chk("ovf up match", 32'(match[2]), 32'd0);
    wr(4'd11, 32'h2);
    rd(4'd11, 32'h0, "ovf clear");
    wr(4'd8, 32'h5);
    wr(4'd8, 32'h0);
    prime(); rd(4'd9, 32'hFF, "ovf down count");
    rd(4'd11, 32'h2, "ovf down status");

    // Load beats step; set beats clear.
    wr(4'd2, 32'h40);
    wr(4'd1, 32'h40);
    wr(4'd0, 32'h1);
    wr(4'd3, 32'h1);
    wr(4'd1, 32'h20);
    rd(4'd1, 32'h20, "load wins");
    rd(4'd3, 32'h1, "set wins");
    chk("set wins match", 32'(match[0]), 32'd1);
    chk("no irq_en", 32'(irq), 32'd0);
    wr(4'd0, 32'h0);

    // Read and write to the same register together.
    bus.avs_address = 4'd6; bus.avs_writedata = 32'h77;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    cyc();
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    chk("rw rdvalid", 32'(bus.avs_readdatavalid), 32'd1);
    chk("rw old value", bus.avs_readdata, 32'h0);
    rd(4'd6, 32'h77, "rw new value");

    // Coherent sample: ch1 read 6 edges after the ch0 read.
    wr(4'd5, 32'h50);
    wr(4'd0, 32'h1);
    wr(4'd4, 32'h1);
    prime();
    repeat (5) cyc();
`ifdef DIRCC_COUNTER_SNAPSHOT_EN
    snap_exp = 32'h50;
`else
    snap_exp = 32'h56;
`endif
    rd(4'd5, snap_exp, "snapshot ch1");

    // Asynchronous reset with a read in flight.
    bus.avs_address = 4'd5;
    bus.avs_read    = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    bus.avs_read = 1'b0;
    chk("mid reset rdvalid", 32'(bus.avs_readdatavalid), 32'd0);
    chk("mid reset rdata", bus.avs_readdata, 32'd0);
    chk("mid reset match", 32'(match), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    prime(); rd(4'd5, 32'h0, "post reset count");
    rd(4'd4, 32'h0, "post reset ctrl");
    rd(4'd6, 32'h0, "post reset compare");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
